// File: rtl/digit_serial_adder.sv
// Digit-serial two's complement adder: WIDTH-bit operands, DIGIT bits per clock.
// Optional add/subtract mode enabled by defining DIGIT_SERIAL_ADDER_ADDSUB_EN.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_ADDSUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  // Ripple of full-adder cells across one digit, fed by the registered carry.
  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_sr[i] ^ b_sr[i] ^ c[i];
      c[i+1]   = (a_sr[i] & b_sr[i]) | (c[i] & (a_sr[i] ^ b_sr[i]));
    end
  end

  // New digit enters at the top so the full sum is aligned after NDIG shifts.
  assign sum_next = (sum_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

`ifdef DIGIT_SERIAL_ADDER_ADDSUB_EN
  assign load_b = sub ? ~b : b;
  assign load_c = sub ? 1'b1 : cin;
`else
  assign load_b = b;
  assign load_c = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= load_b;
            carry <= load_c;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          sum_sr <= sum_next;
          carry  <= c[DIGIT];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= sum_next;
            cout  <= c[DIGIT];
            ovf   <= c[DIGIT] ^ c[DIGIT-1];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: a 16/4 instance and an 8/1 instance,
// compared against an arithmetic reference model.
module tb_digit_serial_adder;

  localparam int NDIG16 = 4;
  localparam int NDIG8  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0, sub8 = 1'b0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] prev_sum = '0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_ADDSUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef DIGIT_SERIAL_ADDER_ADDSUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // Reference: plain integer addition of the operands; subtraction as a + ~b + 1.
  task automatic ref_add(input int w, input logic [63:0] ra, input logic [63:0] rb,
                         input logic rc, input logic rs,
                         output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, bb, full;
    mask = (64'd1 << w) - 64'd1;
    bb   = rs ? (~rb & mask) : (rb & mask);
    full = (ra & mask) + bb + {63'd0, (rs ? 1'b1 : rc)};
    s    = full & mask;
    co   = full[w];
    ov   = (ra[w-1] == bb[w-1]) && (s[w-1] != ra[w-1]);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                               input logic tc, input logic ts,
                               input logic [15:0] es, input logic eco, input logic eov);
    int cycles;
    logic run_ok;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    checkOutput({name, " busy_at_start"}, 32'(busy), 1);
    checkOutput({name, " sum_held"}, 32'(sum), 32'(prev_sum));
    cycles = 0;
    run_ok = 1'b1;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
      if (!done && !busy) run_ok = 1'b0;
    end
    checkOutput({name, " latency"}, 32'(cycles), NDIG16);
    checkOutput({name, " busy_in_run"}, 32'(run_ok), 1);
    checkOutput({name, " busy_at_done"}, 32'(busy), 0);
    checkOutput({name, " sum"}, 32'(sum), 32'(es));
    checkOutput({name, " cout"}, 32'(cout), 32'(eco));
    checkOutput({name, " ovf"}, 32'(ovf), 32'(eov));
    prev_sum = es;
    tick();
    checkOutput({name, " done_pulse"}, 32'(done), 0);
  endtask

  task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input logic [7:0] es, input logic eco, input logic eov);
    int cycles;
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    cycles = 0;
    while (!done8 && cycles < 40) begin
      tick();
      cycles++;
    end
    checkOutput({name, " latency"}, 32'(cycles), NDIG8);
    checkOutput({name, " sum"}, 32'(sum8), 32'(es));
    checkOutput({name, " cout"}, 32'(cout8), 32'(eco));
    checkOutput({name, " ovf"}, 32'(ovf8), 32'(eov));
    tick();
  endtask

  initial begin
    logic [63:0] ms;
    logic mco, mov;
    logic [15:0] ra, rb;
    logic rc, rs;
    logic [15:0] qa[20], qb[20];
    logic qc[20], qs[20];
    logic no_done;

    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
    tbl.push_back('{16'h0FF0, 16'h00F0, 1'b1, 1'b0, 16'h10E1, 1'b0, 1'b0});
`ifdef DIGIT_SERIAL_ADDER_ADDSUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    // Asynchronous reset values, before any clock edge has been seen.
    #2;
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset sum", 32'(sum), 0);
    checkOutput("reset cout", 32'(cout), 0);
    checkOutput("reset ovf", 32'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      applyStimulus($sformatf("table[%0d]", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                    tbl[i].s, tbl[i].co, tbl[i].ov);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef DIGIT_SERIAL_ADDER_ADDSUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      ref_add(16, {48'd0, ra}, {48'd0, rb}, rc, rs, ms, mco, mov);
      applyStimulus($sformatf("rand[%0d]", i), ra, rb, rc, rs, ms[15:0], mco, mov);
    end

    // start held high, fresh operands each cycle: only every fifth edge loads.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      qa[n] = 16'($urandom); qb[n] = 16'($urandom); qc[n] = 1'($urandom);
`ifdef DIGIT_SERIAL_ADDER_ADDSUB_EN
      qs[n] = 1'($urandom);
`else
      qs[n] = 1'b0;
`endif
      a = qa[n]; b = qb[n]; cin = qc[n]; sub = qs[n]; start = 1'b1;
      tick();
      checkOutput($sformatf("b2b[%0d] done", n), 32'(done), 32'(n % 5 == 4));
      checkOutput($sformatf("b2b[%0d] busy", n), 32'(busy), 32'(n % 5 != 4));
      if (n % 5 == 4) begin
        ref_add(16, {48'd0, qa[n-4]}, {48'd0, qb[n-4]}, qc[n-4], qs[n-4], ms, mco, mov);
        checkOutput($sformatf("b2b[%0d] sum", n), 32'(sum), 32'(ms[15:0]));
        checkOutput($sformatf("b2b[%0d] cout", n), 32'(cout), 32'(mco));
        checkOutput($sformatf("b2b[%0d] ovf", n), 32'(ovf), 32'(mov));
        prev_sum = ms[15:0];
      end
    end
    @(negedge clk);
    start = 1'b0;
    tick();

    // Reset two cycles into an operation, away from any clock edge.
    applyStimulus("pre_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy), 0);
    checkOutput("midreset done", 32'(done), 0);
    checkOutput("midreset sum", 32'(sum), 0);
    checkOutput("midreset cout", 32'(cout), 0);
    checkOutput("midreset ovf", 32'(ovf), 0);
    prev_sum = '0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) no_done = 1'b0;
    end
    checkOutput("midreset no_done", 32'(no_done), 1);
    ra = 16'($urandom); rb = 16'($urandom);
    ref_add(16, {48'd0, ra}, {48'd0, rb}, 1'b1, 1'b0, ms, mco, mov);
    applyStimulus("post_reset", ra, rb, 1'b1, 1'b0, ms[15:0], mco, mov);

    // Bit-serial 8-bit instance.
    run8("w8 hand", 8'hB5, 8'h6C, 1'b1, 8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(255)); rb = 16'($urandom_range(255)); rc = 1'($urandom);
      ref_add(8, {48'd0, ra}, {48'd0, rb}, rc, 1'b0, ms, mco, mov);
      run8($sformatf("w8 rand[%0d]", i), ra[7:0], rb[7:0], rc, ms[7:0], mco, mov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, sequential two's complement adder.
- Adds two WIDTH-bit operands DIGIT bits per clock using a DIGIT-wide ripple of single-bit full-adder cells and a registered carry between digits.
- Start/busy/done handshake.
- Used as the accumulate stage of the sequential multiplier datapath, and wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 gives a pure bit-serial adder, DIGIT=WIDTH gives a single-cycle registered adder.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; operands sampled when start=1 and busy=0
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- cin  input  1  carry into bit 0
- sub  input  1  subtract request (only present with ADDSUB_EN)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Derived constant: NDIG = WIDTH/DIGIT. The digit counter is clog2(NDIG) bits, minimum 1.
- Reset values (on rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and counter cleared.

State machine:
- IDLE:
  - start=1 at an edge: load A and B shift registers from a and b, carry register <= cin, counter <= 0, go to RUN.
  - start=0: stay in IDLE.
- RUN: each edge performs the following.
  - Add the low DIGIT bits of A, B and carry through the full-adder chain.
  - Shift A and B right by DIGIT.
  - Shift the digit sum into the top of the sum shift register.
  - Carry register <= chain carry-out.
  - Counter increments.
  - On the edge processing digit NDIG-1: register sum, cout and ovf, go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in this cycle is accepted (same load as IDLE), go to RUN.
  - Otherwise go to IDLE.

Handshake and timing:
- busy=1 exactly while state=RUN.
- done rises NDIG cycles after the start-sampling edge; 4 cycles for the defaults.
- Back-to-back throughput is one result per NDIG+1 cycles.
- start while busy=1 is ignored; the in-flight operation and operands are unaffected.
- a, b and cin need only be valid on the sampling edge.

Results:
- sum, cout and ovf change only on the edge that enters DONE. They hold their value through IDLE and subsequent RUN until the next completion.
- ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), taken inside the last digit's chain.
- cout = carry out of bit WIDTH-1.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset mid-operation: immediate abort to the reset values; no done pulse is produced.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_ADDSUB_EN.
- Defined:
  - sub port exists, sampled with the operands.
  - sub=1 computes a - b: B is loaded as ~b and the initial carry is forced to 1; cin is ignored.
  - cout=1 means no borrow; ovf is signed subtraction overflow.
  - sub=0 behaves as the add-only build.
- Undefined: no sub port; add only.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x1234, b=0x4321, cin=0, start pulse.
  - busy=1 for 4 cycles; done pulse 4 cycles after the start edge.
  - sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Start and busy interaction: start held high continuously with new operands every cycle.
  - Only the operands at the IDLE edge and at each DONE-cycle edge are taken; results arrive every 5 cycles.
  - Operand changes during RUN have no effect.
- Reset mid-operation: rst_n=0 asserted mid-cycle, two cycles after start, with no clock edge.
  - busy, done, sum, cout and ovf are 0 immediately.
  - No done pulse follows.
  - A new start after release gives the correct result.
- ADDSUB_EN, WIDTH=16: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- WIDTH=8, DIGIT=1: a=0xB5, b=0x6C, cin=1 -> done 8 cycles after start; sum=0x22, cout=1, ovf=0.
